hack_boot_ctrl: RTL and testbench
=================================

# hack_boot_ctrl

Boot and run controller for the Hack CPU subsystem. It receives a program image as a byte stream from the host and writes it word-by-word into the instruction ROM. It holds the CPU in reset until the image is loaded, then releases it and counts run cycles. It detects the Hack end-of-program idiom (a tight jump loop) and reports halt status and halt address back to the host.

## Interface

Parameters:
- ADDR_W, 15, instruction ROM address width; ROM depth is 2^ADDR_W words.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- s_data  in  8  host stream byte.
- s_valid  in  1  host byte valid.
- s_ready  out  1  controller accepts byte; transfer when s_valid & s_ready.
- reload  in  1  single-cycle request: abort current activity and start a new load.
- rom_we  out  1  instruction ROM write strobe, one cycle per word.
- rom_addr  out  ADDR_W  ROM write address.
- rom_wdata  out  16  ROM write data.
- cpu_pc  in  16  CPU program counter.
- cpu_reset  out  1  active-high synchronous reset to the CPU.
- busy  out  1  high while a load is in progress (states LEN_HI through START).
- running  out  1  high in RUN.
- halted  out  1  high in HALT.
- halt_pc  out  16  loop start address captured at halt detection.
- cycle_count  out  32  number of RUN cycles; saturates at 0xFFFF_FFFF.

## Operation

- Stream frame format: LEN_HI, LEN_LO (word count N, big-endian), then N words, each sent high byte first.
- States and transitions:
  - LEN_HI: after the byte is accepted, go to LEN_LO.
  - LEN_LO: after the byte is accepted, latch N. Go to START if N==0, else go to DATA_HI.
  - DATA_HI: after the byte is accepted, hold it in a register and go to DATA_LO.
  - DATA_LO: after the byte is accepted, issue the word write. Go to START if this is word N-1, else go to DATA_HI.
  - START: one cycle, then go to RUN.
  - RUN: go to HALT on halt detection.
  - HALT: terminal; leave only on reload.
- s_ready is 1 in LEN_HI, LEN_LO, DATA_HI and DATA_LO, gated by ~reload. It is 0 in START, RUN and HALT, and 0 while rstn is low.
- Word write:
  - rom_we is registered and pulses on the edge after the DATA_LO acceptance.
  - rom_addr = word index k, where k counts from 0.
  - rom_wdata = {hi, lo}.
  - Words with k ≥ 2^ADDR_W are consumed but not written (rom_we stays 0).
- cpu_reset is 1 in every state except RUN and HALT.
- cycle_count:
  - Cleared when entering LEN_HI.
  - Increments once per cycle in RUN; frozen in HALT.
- Halt detection:
  - Keep a 3-entry history of cpu_pc (h0 = current, h1, h2), sampled every RUN cycle.
  - Detection is armed once cycle_count ≥ 3.
  - Halt when h0==h1 (self-jump), or when h0==h2 and h1==h0+1 (the two-instruction "@L; 0;JMP" loop at L).
  - halt_pc = h0 in both cases.
- Reload:
  - When reload is sampled high in any state, go to LEN_HI on the next edge.
  - That edge also clears k, N, cycle_count, halt_pc, halted and the pc history, and asserts cpu_reset.
  - A byte presented in the same cycle as reload is not accepted, because s_ready is 0.
- Reset values: state LEN_HI, cpu_reset=1, rom_we=0, rom_addr=0, rom_wdata=0, busy=1, running=0, halted=0, halt_pc=0, cycle_count=0.

## Timing

- Byte acceptance: at most one byte per cycle; s_valid may drop at any time without penalty.
- Minimum load for N words: 2 + 2N accepted bytes, then one START cycle, then RUN.
- The final rom_we pulse occurs during START. It therefore completes before cpu_reset falls, so the CPU never fetches a word that is still being written.
- cpu_reset deasserts on the edge that enters RUN. cpu_pc is 0 during the first RUN cycle, provided cpu_reset was high for at least one edge beforehand.
- halted rises on the edge after the detecting cycle. running falls on the same edge.
- cycle_count is not reset by halt. It saturates without wrapping.
- Asserting rstn mid-load or mid-run forces all reset values immediately (asynchronously).

## Test plan

- Load N=3, words 0x0002, 0xEC10, 0x0000 with continuous s_valid → rom_we pulses at addr 0,1,2 with matching data; START lasts 1 cycle; cpu_reset falls; running=1.
- Frame 00 00 (N=0) → no rom_we; START, then RUN; cycle_count increments from 0.
- Model cpu_pc sequence 0,1,2,3,4,3,4,3 → halted=1 with halt_pc=3; cycle_count freezes at the detecting count. Second case: pc held at 7 → halt_pc=7.
- Stall s_valid randomly mid-word (between hi and lo) → data is assembled correctly; no spurious rom_we; s_ready stays 1.
- With ADDR_W=2, send N=6 → rom_we only for k=0..3; all 12 data bytes are accepted; RUN is entered afterwards.
- Pulse reload during DATA_LO and again in HALT, each with s_valid=1 in the same cycle → byte not accepted; next state LEN_HI; cpu_reset=1; cycle_count=0; halted=0. Pulling rstn low mid-RUN restores reset values immediately.

Source files
------------

// File: rtl/hack_boot_ctrl.sv
// hack_boot_ctrl: loads a byte-streamed Hack program into ROM, then releases the CPU and watches for its halt loop
module hack_boot_ctrl #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              reload,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  input  logic [15:0]       cpu_pc,
  output logic              cpu_reset,
  output logic              busy,
  output logic              running,
  output logic              halted,
  output logic [15:0]       halt_pc,
  output logic [31:0]       cycle_count
);
  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA_HI, DATA_LO, START, RUN, HALT} state_e;
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;
  state_e state_q, state_d;
  logic [15:0] n_q, n_d, k_q, k_d, wdata_q, wdata_d, hpc_q, hpc_d, h1_q, h1_d, h2_q, h2_d;
  logic [7:0] hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] cnt_q, cnt_d;
  logic we_q, we_d, in_load, acc, detect;
  assign in_load = state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO};
  assign s_ready = rstn & in_load & ~reload;
  assign acc = s_valid & s_ready;
  assign detect = (state_q == RUN) && (cnt_q >= 32'd3) &&
                  ((cpu_pc == h1_q) || (cpu_pc == h2_q && h1_q == 16'(cpu_pc + 16'd1)));
  assign cpu_reset = ~(state_q inside {RUN, HALT});
  assign busy = in_load | (state_q == START);
  assign running = state_q == RUN;
  assign halted = state_q == HALT;
  assign rom_we = we_q;
  assign rom_addr = addr_q;
  assign rom_wdata = wdata_q;
  assign halt_pc = hpc_q;
  assign cycle_count = cnt_q;
  // next state: frame parsing, word writes, run counting and halt detection; reload overrides all
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    k_d = k_q;
    hi_d = hi_q;
    we_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    hpc_d = hpc_q;
    h1_d = h1_q;
    h2_d = h2_q;
    cnt_d = cnt_q;
    if (reload) begin
      state_d = LEN_HI;
      n_d = '0;
      k_d = '0;
      hpc_d = '0;
      h1_d = '0;
      h2_d = '0;
      cnt_d = '0;
    end else begin
      case (state_q)
        LEN_HI: if (acc) begin
          n_d = {s_data, 8'h00};
          state_d = LEN_LO;
        end
        LEN_LO: if (acc) begin
          n_d = {n_q[15:8], s_data};
          state_d = ({n_q[15:8], s_data} == 16'd0) ? START : DATA_HI;
        end
        DATA_HI: if (acc) begin
          hi_d = s_data;
          state_d = DATA_LO;
        end
        DATA_LO: if (acc) begin
          we_d = {1'b0, k_q} < DEPTH;
          addr_d = k_q[ADDR_W-1:0];
          wdata_d = {hi_q, s_data};
          k_d = k_q + 16'd1;
          state_d = (k_q == n_q - 16'd1) ? START : DATA_HI;
        end
        START: state_d = RUN;
        RUN: begin
          cnt_d = &cnt_q ? cnt_q : cnt_q + 32'd1;
          h1_d = cpu_pc;
          h2_d = h1_q;
          state_d = detect ? HALT : RUN;
          hpc_d = detect ? cpu_pc : hpc_q;
        end
        HALT: ;
        default: state_d = LEN_HI;
      endcase
    end
  end
  // state register with asynchronous reset to the idle load state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= LEN_HI;
      n_q <= '0;
      k_q <= '0;
      hi_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      hpc_q <= '0;
      h1_q <= '0;
      h2_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      k_q <= k_d;
      hi_q <= hi_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      hpc_q <= hpc_d;
      h1_q <= h1_d;
      h2_q <= h2_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hack_boot_ctrl.sv
// tb_hack_boot_ctrl: directed frames against a byte-count/pc-history model, full-depth and 4-word ROM instances
module tb_hack_boot_ctrl;
  logic clk = 1'b0, rstn = 1'b0, s_valid = 1'b0, reload = 1'b0;
  logic [7:0] s_data = '0;
  logic [15:0] cpu_pc = '0;
  logic s_ready, rom_we, cpu_reset, busy, running, halted;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata, halt_pc;
  logic [31:0] cycle_count;
  logic s_ready_s, rom_we_s, cpu_reset_s, busy_s, running_s, halted_s;
  logic [1:0] rom_addr_s;
  logic [15:0] rom_wdata_s, halt_pc_s;
  logic [31:0] cycle_count_s;
  int errs = 0, checks = 0, wcnt = 0, wcnt_s = 0;
  int wa[$], wd[$];
  logic [7:0] fb[$];
  int ph = 0, nb = 0, n = 0, k = 0, ea = 0, pcs[$];
  logic [7:0] hi = '0;
  logic [15:0] ed = '0, hpc = '0;
  longint cyc = 0;
  bit ew = 0, ew_s = 0;

  hack_boot_ctrl #(.ADDR_W(15)) dut (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .reload(reload), .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_pc(cpu_pc), .cpu_reset(cpu_reset), .busy(busy), .running(running),
    .halted(halted), .halt_pc(halt_pc), .cycle_count(cycle_count));
  hack_boot_ctrl #(.ADDR_W(2)) dut_s (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_s),
    .reload(reload), .rom_we(rom_we_s), .rom_addr(rom_addr_s), .rom_wdata(rom_wdata_s),
    .cpu_pc(cpu_pc), .cpu_reset(cpu_reset_s), .busy(busy_s), .running(running_s),
    .halted(halted_s), .halt_pc(halt_pc_s), .cycle_count(cycle_count_s));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: phase 0 load, 1 start, 2 run, 3 halt; load progress tracked as a byte count against 2+2N
  always @(posedge clk or negedge rstn) begin
    if (!rstn || reload) begin
      ph = 0; nb = 0; n = 0; cyc = 0; pcs.delete(); hpc = '0; ew = 0; ew_s = 0;
    end else begin
      ew = 0; ew_s = 0;
      case (ph)
        0: if (s_valid) begin
          if (nb == 0) n = int'(s_data) * 256;
          else if (nb == 1) n = n + int'(s_data);
          else if (nb % 2 == 0) hi = s_data;
          else begin
            k = (nb - 3) / 2;
            ew = k < 32768; ew_s = k < 4; ea = k; ed = {hi, s_data};
          end
          nb++;
          if (nb >= 2 && nb == 2 + 2 * n) ph = 1;
        end
        1: ph = 2;
        2: begin
          pcs.push_back(int'(cpu_pc));
          if (cyc >= 3) begin
            int a, b, c;
            a = pcs[pcs.size()-1]; b = pcs[pcs.size()-2]; c = pcs[pcs.size()-3];
            if (a == b || (a == c && b == ((a + 1) % 65536))) begin
              ph = 3; hpc = a[15:0];
            end
          end
          if (cyc < 64'hFFFF_FFFF) cyc++;
        end
        default: ;
      endcase
    end
  end

  // compare every cycle at the falling edge
  always @(negedge clk) begin
    chk("s_ready", s_ready, rstn && ph == 0 && !reload);
    chk("busy", busy, ph <= 1);
    chk("running", running, ph == 2);
    chk("halted", halted, ph == 3);
    chk("cpu_reset", cpu_reset, ph <= 1);
    chk("cycle_count", cycle_count, cyc);
    chk("halt_pc", halt_pc, hpc);
    chk("rom_we", rom_we, ew);
    if (ew) begin
      chk("rom_addr", rom_addr, ea);
      chk("rom_wdata", rom_wdata, ed);
    end
    chk("rom_we_s", rom_we_s, ew_s);
    if (ew_s) begin
      chk("rom_addr_s", rom_addr_s, ea);
      chk("rom_wdata_s", rom_wdata_s, ed);
    end
    chk("running_s", running_s, ph == 2);
    if (rom_we === 1'b1) begin
      wcnt++; wa.push_back(int'(rom_addr)); wd.push_back(int'(rom_wdata));
    end
    if (rom_we_s === 1'b1) wcnt_s++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input bit stall);
    for (int i = 0; i < fb.size(); i++) begin
      if (stall && i >= 3 && i % 2 == 1) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      s_valid = 1'b1; s_data = fb[i];
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_run();
    int budget = 0;
    cpu_pc = '0;
    while (running !== 1'b1 && budget < 50) begin tick(); budget++; end
    chk("entered_run", running, 1);
  endtask

  task automatic run_pc(input int mode);
    int seq[8] = '{0, 1, 2, 3, 4, 3, 4, 3};
    int i = 0;
    wait_run();
    while (halted !== 1'b1 && i < 50) begin
      cpu_pc = mode == 0 ? 16'(seq[i < 8 ? i : 7]) : (i == 0 ? 16'd0 : (mode == 1 ? 16'd7 : 16'd5));
      tick(); i++;
    end
    chk("halt_reached", halted, 1);
    cpu_pc = '0;
  endtask

  task automatic do_reload();
    reload = 1'b1; s_valid = 1'b1; s_data = 8'h55;
    tick();
    reload = 1'b0; s_valid = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_rom_we", rom_we, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rom_wdata", rom_wdata, 0);
    chk("rst_busy", busy, 1);
    chk("rst_running", running, 0);
    chk("rst_halted", halted, 0);
    chk("rst_halt_pc", halt_pc, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_s_ready", s_ready, 0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    fb = '{8'h00, 8'h03, 8'h00, 8'h02, 8'hEC, 8'h10, 8'h00, 8'h00};
    send(0);
    run_pc(0);
    chk("t1_halt_pc", halt_pc, 3);
    chk("t1_cycle_count", cycle_count, 6);
    chk("t1_writes", wcnt, 3);
    chk("t1_a0", wa[0], 0); chk("t1_d0", wd[0], 16'h0002);
    chk("t1_a1", wa[1], 1); chk("t1_d1", wd[1], 16'hEC10);
    chk("t1_a2", wa[2], 2); chk("t1_d2", wd[2], 16'h0000);
    repeat (2) tick();
    chk("t1_frozen", cycle_count, 6);
    do_reload();
    chk("rl_halted", halted, 0);
    chk("rl_cycle_count", cycle_count, 0);
    chk("rl_cpu_reset", cpu_reset, 1);
    chk("rl_halt_pc", halt_pc, 0);
    fb = '{8'h00, 8'h00};
    send(0);
    run_pc(1);
    chk("t2_halt_pc", halt_pc, 7);
    chk("t2_cycle_count", cycle_count, 4);
    chk("t2_writes", wcnt, 3);
    do_reload();
    fb = '{8'h00, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
           8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    send(1);
    run_pc(2);
    chk("t3_halt_pc", halt_pc, 5);
    chk("t3_writes", wcnt, 9);
    chk("t3_writes_s", wcnt_s, 7);
    chk("t3_last_a", wa[wa.size()-1], 5);
    chk("t3_last_d", wd[wd.size()-1], 16'hBBCC);
    do_reload();
    fb = '{8'h00, 8'h02, 8'h12};
    send(0);
    do_reload();
    chk("t4_busy", busy, 1);
    chk("t4_cpu_reset", cpu_reset, 1);
    chk("t4_no_write", wcnt, 9);
    fb = '{8'h00, 8'h01, 8'hAB, 8'hCD};
    send(0);
    wait_run();
    chk("t4_a", wa[wa.size()-1], 0);
    chk("t4_d", wd[wd.size()-1], 16'hABCD);
    tick(); tick();
    #3 rstn = 1'b0;
    #1;
    chk("ar_running", running, 0);
    chk("ar_cpu_reset", cpu_reset, 1);
    chk("ar_busy", busy, 1);
    chk("ar_cycle_count", cycle_count, 0);
    chk("ar_s_ready", s_ready, 0);
    chk("ar_rom_we", rom_we, 0);
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
